// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU for the execute stage, with an
// architectural {V,C,N,Z} flags register. Single-cycle ops (ADD, SUB, AND,
// ORR, EOR, LSL) complete on the issuing edge. MUL is an iterative shift-add
// that holds busy high for WIDTH cycles.
// Ports: clk/rst_n (async active-low), start/opcode/A/B/flag_we issue inputs,
//        busy (MUL iterating, start ignored), done (1-cycle result pulse),
//        result (held until the next completion), ALUFlags {V,C,N,Z}.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flag_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ALUFlags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic             mul_we;
  logic             flag_v, flag_c, flag_n, flag_z;

  logic             issue, mul_go, mul_step, mul_last;

  // single-cycle datapath
  logic             op_mul, op_rsvd;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum, diff, shl;
  logic [SHW-1:0]   sh;

  assign ALUFlags = {flag_v, flag_c, flag_n, flag_z};

  // Combinational result/flags for every single-cycle opcode. alu_c/alu_v
  // default to the current flags so that ops which preserve C/V can share
  // one flag-write path.
  always_comb begin
    op_mul  = MUL_EN && (opcode == 3'b101);
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    sh      = B[SHW-1:0];
    // One extra bit on top catches the last bit shifted out.
    shl     = {1'b0, A} << sh;
    alu_r   = '0;
    alu_c   = flag_c;
    alu_v   = flag_v;
    op_rsvd = 1'b0;
    case (opcode)
      3'b000: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[MSB] == B[MSB]) && (alu_r[MSB] != A[MSB]);
      end
      3'b001: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = ~diff[WIDTH];  // no borrow means A >= B
        alu_v = (A[MSB] != B[MSB]) && (alu_r[MSB] != A[MSB]);
      end
      3'b010: alu_r = A & B;
      3'b011: alu_r = A | B;
      3'b100: alu_r = A ^ B;
      3'b110: begin
        alu_r = shl[WIDTH-1:0];
        if (sh != '0) alu_c = shl[WIDTH];
      end
      default: op_rsvd = !op_mul;  // 101 (MUL path or reserved) and 111
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && op_mul) state_nxt = MUL;
      MUL:     if (count == SHW'(WIDTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs and datapath controls
  always_comb begin
    busy     = (state == MUL);
    issue    = start && (state == IDLE);
    mul_go   = issue && op_mul;
    mul_step = (state == MUL);
    mul_last = mul_step && (count == SHW'(WIDTH - 1));
    acc_nxt  = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      done   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mul_we <= 1'b0;
      flag_v <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      done <= 1'b0;

      if (issue && !op_mul) begin
        result <= alu_r;
        done   <= 1'b1;
        if (flag_we && !op_rsvd) begin
          flag_v <= alu_v;
          flag_c <= alu_c;
          flag_n <= alu_r[MSB];
          flag_z <= (alu_r == '0);
        end
      end

      if (mul_go) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        count  <= '0;
        mul_we <= flag_we;  // inputs may change during MUL; keep the request
      end

      if (mul_step) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        // The final iteration's partial product is folded in directly.
        if (mul_last) begin
          result <= acc_nxt;
          done   <= 1'b1;
          if (mul_we) begin
            flag_n <= acc_nxt[MSB];
            flag_z <= (acc_nxt == '0);
          end
        end
      end
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered multi-cycle ALU for the datapath's execute stage.
- Single-cycle ops: ADD, SUB, AND, ORR, EOR, LSL. MUL is an iterative shift-add over WIDTH cycles.
- Holds the architectural flags register, written only when the issuing instruction requests it.
- Uses a start/busy/done handshake so the control FSM can stall while MUL iterates.

Parameters:
- WIDTH, 32: operand, result and datapath width. Minimum 4; power of two.
- MUL_EN, 1: 1 enables MUL. With 0, MUL behaves as the reserved opcode.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue request, sampled on the rising edge
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 LSL, 111 reserved
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- flag_we  in  1  update the flags register when this op completes
- busy  out  1  MUL in progress; start is ignored while high
- done  out  1  one-cycle pulse: result is valid
- result  out  WIDTH  registered result; holds until the next completion
- ALUFlags  out  4  {V, C, N, Z} flags register

Behaviour:
- Reset (async, rst_n=0):
  - result=0, ALUFlags=0, busy=0, done=0, FSM to IDLE, iteration counter=0.
  - Reset mid-MUL aborts the op: no done pulse, no flag write.
- FSM states: IDLE, MUL.
- IDLE:
  - start=1 with a single-cycle op: result, done=1 and flags (if flag_we) are registered on the same edge. Latency is 1 cycle, busy stays 0.
  - start=1 with MUL: latches multiplicand=A, multiplier=B, acc=0, flag_we. Sets busy=1, count=0, and goes to MUL.
- MUL, each edge:
  - If multiplier[0]=1: acc += multiplicand (mod 2^WIDTH).
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge where count reaches WIDTH-1: result = final acc, done=1, busy=0, go to IDLE.
  - busy is high for exactly WIDTH cycles; done follows the start edge by WIDTH+1 edges.
- done:
  - Is 0 on every cycle except the one after a completing edge.
  - Back-to-back single-cycle starts give done high on consecutive cycles.
- start while busy=1: ignored, with no queueing. A, B, opcode and flag_we may change freely during MUL.
- Arithmetic, all WIDTH-bit:
  - ADD: {c, r} = A + B (WIDTH+1 bits). V = (A[msb]==B[msb]) & (r[msb]!=A[msb]).
  - SUB: r = A - B. C = 1 when A >= B unsigned (no borrow). V = (A[msb]!=B[msb]) & (r[msb]!=A[msb]).
  - AND/ORR/EOR: bitwise.
  - LSL: r = A << B[log2(WIDTH)-1:0]. C = last bit shifted out; C unchanged when the shift amount is 0.
  - MUL: low WIDTH bits of the unsigned product.
- Flag rules, applied only when the latched flag_we=1:
  - N = r[msb] and Z = (r == 0) for every op except reserved.
  - ADD/SUB update C and V.
  - LSL updates C; V is preserved.
  - AND/ORR/EOR/MUL preserve C and V.
- Reserved opcode (and MUL with MUL_EN=0): result=0, done pulses, flags never written.
- flag_we=0: the flags register is unchanged; result and done still update.

Test Plan:
- ADD with WIDTH=32: A=0x7FFFFFFF, B=1, flag_we=1 -> result=0x80000000, ALUFlags=4'b1010 (V, N), done one cycle after start.
- SUB: A=5, B=5, flag_we=1 -> result=0, ALUFlags=4'b0101 (C, Z). Follow with AND A=0xF0, B=0x0F, flag_we=1 -> result=0, ALUFlags=4'b0101 (C preserved, Z set).
- MUL: A=0x0000FFFF, B=0x00010001, flag_we=1 -> busy high 32 cycles, result=0xFFFFFFFF with done at start edge +33, ALUFlags N=1, Z=0, C/V unchanged. A second start pulsed mid-op is ignored: exactly one done.
- flag_we=0: ADD 0xFFFFFFFF+1 -> result=0, ALUFlags unchanged from its prior value. LSL A=0x80000001, B=1, flag_we=1 -> result=0x00000002, C=1, V unchanged.
- Reset: rst_n low 10 cycles into a MUL -> busy=0, done=0, result=0, ALUFlags=0 immediately (async). No done afterwards, and a new ADD completes normally.
- WIDTH=8, MUL_EN=0 instance: ADD 0xFF+0x01 -> result=0x00, ALUFlags=4'b0101. MUL opcode -> result=0, done pulses, flags unchanged.
